traffic_light_fsm: RTL and testbench
====================================

TRAFFIC_LIGHT_FSM -- requirements
Module: traffic_light_fsm

Interface
REQ-001 The block SHALL have one clock, clk; reset is asynchronous and active-high, port Reset.
REQ-002 Parameter T_BASE SHALL default to 6 and set the base green duration in Tick pulses.
REQ-003 Parameter T_EXT SHALL default to 3 and set the extension and walk duration in Tick pulses.
REQ-004 Parameter T_YEL SHALL default to 2 and set the yellow duration in Tick pulses.
REQ-005 Parameter TW SHALL default to 4 and set the timer width; every duration SHALL be 1..2^TW-1, and 0 is illegal.
REQ-006 clk SHALL be an input, 1 bit: system clock.
REQ-007 Reset SHALL be an input, 1 bit: asynchronous active-high reset.
REQ-008 Sensor_Sync SHALL be an input, 1 bit: synchronized side-street vehicle sensor.
REQ-009 WR_Sync SHALL be an input, 1 bit: synchronized walk request, level-sensitive.
REQ-010 Prog_Sync SHALL be an input, 1 bit: synchronized reprogram/restart request.
REQ-011 Tick SHALL be an input, 1 bit: one-clk-wide timebase enable (nominal 1 Hz).
REQ-012 LED_main SHALL be an output, 3 bits, {R,Y,G}: main-street lamps.
REQ-013 LED_side SHALL be an output, 3 bits, {R,Y,G}: side-street lamps.
REQ-014 Walk_Lamp SHALL be an output, 1 bit: pedestrian walk lamp.
REQ-015 State SHALL be an output, 3 bits: current state encoding, for debug.

Function
REQ-016 The FSM SHALL implement 7 states, with encodings and durations:
- MG1 (0): T_BASE.
- MG2 (1): T_EXT if Sensor_Sync=1 on the MG1 exit edge, else T_BASE.
- MY (2): T_YEL.
- WALK (3): T_EXT.
- SG (4): T_BASE.
- SGX (5): T_EXT.
- SY (6): T_YEL.
- Encoding 7 is unused and SHALL recover to MG1 on the next clk.
REQ-017 Transitions SHALL be:
- MG1->MG2, MG2->MY.
- MY->WALK if walk latch=1, else MY->SG.
- WALK->SG.
- SG->SGX if Sensor_Sync=1 on the exit edge, else SG->SY.
- SGX->SY, SY->MG1.
REQ-018 The timer SHALL be a TW-bit down-counter, loaded with the next state's duration on every state entry, and decremented only on clk edges where Tick=1.
REQ-019 A state SHALL exit on the clk edge where Tick=1 and the counter=1, so it lasts exactly N Tick pulses; no transition SHALL occur without Tick.
REQ-020 Lamps SHALL be registered and a pure function of state; they SHALL change on the same edge as the state (zero additional latency).
- MG1/MG2: main G, side R.
- MY: main Y, side R.
- WALK: main R, side R, Walk_Lamp=1.
- SG/SGX: main R, side G.
- SY: main R, side Y.
REQ-021 Exactly one lamp bit per 3-bit output SHALL be high at all times, and Walk_Lamp SHALL be 1 only in WALK.
REQ-022 The walk latch SHALL set on any clk where WR_Sync=1, except while in WALK, where WR_Sync is ignored.
REQ-023 The walk latch SHALL clear on the edge entering WALK.
REQ-024 A walk request arriving while in MY SHALL still be served at that MY exit, provided it is latched before the exit edge.
REQ-025 On any clk where Prog_Sync=1, the block SHALL synchronously restart: enter MG1, load the timer with T_BASE, and clear the walk latch.
REQ-026 Prog_Sync SHALL take priority over Tick and over all transitions on that edge.
REQ-027 While Prog_Sync is held high, the FSM SHALL remain in MG1 with the timer held at T_BASE.
REQ-028 Sensor_Sync SHALL be sampled only on the MG1 and SG exit edges; sensor changes at other times SHALL have no effect.

Reset
REQ-029 Asserting Reset SHALL immediately, without waiting for clk, force:
- State=MG1, timer=T_BASE, walk latch=0.
- LED_main=3'b001, LED_side=3'b100, Walk_Lamp=0.
REQ-030 On Reset deassertion, the first Tick SHALL count toward the MG1 duration.

Verification
REQ-031 Scenario: Tick tied 1, Sensor_Sync=0, WR_Sync=0 -> required response: state sequence MG1(6 clk), MG2(6), MY(2), SG(6), SY(2), with a repeating period of 22 clk.
REQ-032 Scenario: Tick tied 1, Sensor_Sync=1 throughout -> required response: MG2 lasts 3 clk, SGX follows SG for 3 clk, and the period is 22 clk.
REQ-033 Scenario: WR_Sync pulsed 1 clk during MG1 -> required response: WALK follows MY for 3 clk with LED_main=LED_side=3'b100 and Walk_Lamp=1, then SG; the next cycle has no WALK.
REQ-034 Scenario: Prog_Sync pulsed during SG, in the same clk as Tick -> required response: next State=0 and LED_main=3'b001; MG1 then lasts 6 Ticks and the pending walk request is discarded.
REQ-035 Scenario: Reset asserted mid-SY between clk edges -> required response: outputs take their reset values before the next clk edge; after release, the sequence restarts at MG1.
REQ-036 Scenario: Tick pulsed every 4th clk -> required response: MY lasts exactly 8 clk, and State never changes on a clk where Tick=0.

Source files
------------

// File: rtl/traffic_light_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : traffic_light_fsm
//  Brief    : Main/side street intersection controller with sensor-driven
//             green extension, latched pedestrian walk phase and synchronous
//             reprogram restart. All durations are counted in Tick pulses.
//  Revision : 1.0 - initial release
// ============================================================================
module traffic_light_fsm #(
    parameter int T_BASE = 6,   // base green duration (Ticks)
    parameter int T_EXT  = 3,   // extension / walk duration (Ticks)
    parameter int T_YEL  = 2,   // yellow duration (Ticks)
    parameter int TW     = 4    // timer width; every duration must be 1..2^TW-1
) (
    input  logic       clk,
    input  logic       Reset,
    input  logic       Sensor_Sync,
    input  logic       WR_Sync,
    input  logic       Prog_Sync,
    input  logic       Tick,
    output logic [2:0] LED_main,
    output logic [2:0] LED_side,
    output logic       Walk_Lamp,
    output logic [2:0] State
);

    // State encodings (also visible on the State debug port)
    localparam logic [2:0] c_MG1  = 3'd0;
    localparam logic [2:0] c_MG2  = 3'd1;
    localparam logic [2:0] c_MY   = 3'd2;
    localparam logic [2:0] c_WALK = 3'd3;
    localparam logic [2:0] c_SG   = 3'd4;
    localparam logic [2:0] c_SGX  = 3'd5;
    localparam logic [2:0] c_SY   = 3'd6;
    localparam logic [2:0] c_BAD  = 3'd7;

    // Timer reload values
    localparam logic [TW-1:0] c_DUR_BASE = TW'(T_BASE);
    localparam logic [TW-1:0] c_DUR_EXT  = TW'(T_EXT);
    localparam logic [TW-1:0] c_DUR_YEL  = TW'(T_YEL);
    localparam logic [TW-1:0] c_ONE      = TW'(1);

    // Lamp patterns, {R,Y,G}
    localparam logic [2:0] c_LAMP_R = 3'b100;
    localparam logic [2:0] c_LAMP_Y = 3'b010;
    localparam logic [2:0] c_LAMP_G = 3'b001;

    logic [2:0]    state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          walk_q, walk_d;
    logic [2:0]    main_q, main_d;
    logic [2:0]    side_q, side_d;
    logic          walk_lamp_q, walk_lamp_d;
    logic          w_expire;

    // The current state ends on the Tick that consumes its last count
    assign w_expire = Tick && (timer_q == c_ONE);

    // Next state, timer reload/decrement and walk-request latch
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        walk_d  = walk_q;
        if (Prog_Sync) begin
            // Restart overrides any Tick or transition on this edge
            state_d = c_MG1;
            timer_d = c_DUR_BASE;
            walk_d  = 1'b0;
        end else begin
            // Requests are ignored while the walk phase is already running
            if (WR_Sync && (state_q != c_WALK)) begin
                walk_d = 1'b1;
            end
            if (state_q == c_BAD) begin
                state_d = c_MG1;
                timer_d = c_DUR_BASE;
            end else if (w_expire) begin
                // Each entry reloads the timer with the new state's duration;
                // the sensor only matters on the MG1 and SG exit edges.
                case (state_q)
                    c_MG1: begin
                        state_d = c_MG2;
                        timer_d = Sensor_Sync ? c_DUR_EXT : c_DUR_BASE;
                    end
                    c_MG2: begin
                        state_d = c_MY;
                        timer_d = c_DUR_YEL;
                    end
                    c_MY: begin
                        if (walk_q) begin
                            state_d = c_WALK;
                            timer_d = c_DUR_EXT;
                            walk_d  = 1'b0;
                        end else begin
                            state_d = c_SG;
                            timer_d = c_DUR_BASE;
                        end
                    end
                    c_WALK: begin
                        state_d = c_SG;
                        timer_d = c_DUR_BASE;
                    end
                    c_SG: begin
                        if (Sensor_Sync) begin
                            state_d = c_SGX;
                            timer_d = c_DUR_EXT;
                        end else begin
                            state_d = c_SY;
                            timer_d = c_DUR_YEL;
                        end
                    end
                    c_SGX: begin
                        state_d = c_SY;
                        timer_d = c_DUR_YEL;
                    end
                    default: begin
                        state_d = c_MG1;
                        timer_d = c_DUR_BASE;
                    end
                endcase
            end else if (Tick) begin
                timer_d = timer_q - c_ONE;
            end
        end
    end

    // Lamps decoded from the next state so they register on the same edge
    always_comb begin
        main_d      = c_LAMP_G;
        side_d      = c_LAMP_R;
        walk_lamp_d = 1'b0;
        case (state_d)
            c_MY: begin
                main_d = c_LAMP_Y;
            end
            c_WALK: begin
                main_d      = c_LAMP_R;
                walk_lamp_d = 1'b1;
            end
            c_SG, c_SGX: begin
                main_d = c_LAMP_R;
                side_d = c_LAMP_G;
            end
            c_SY: begin
                main_d = c_LAMP_R;
                side_d = c_LAMP_Y;
            end
            default: ;
        endcase
    end

    // State, timer, latch and lamp registers with immediate reset
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state_q     <= c_MG1;
            timer_q     <= c_DUR_BASE;
            walk_q      <= 1'b0;
            main_q      <= c_LAMP_G;
            side_q      <= c_LAMP_R;
            walk_lamp_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            walk_q      <= walk_d;
            main_q      <= main_d;
            side_q      <= side_d;
            walk_lamp_q <= walk_lamp_d;
        end
    end

    assign State     = state_q;
    assign LED_main  = main_q;
    assign LED_side  = side_q;
    assign Walk_Lamp = walk_lamp_q;

endmodule
`default_nettype wire

// File: tb/tb_traffic_light_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : tb_traffic_light_fsm
//  Brief    : Self-checking bench for traffic_light_fsm (default parameters):
//             directed vector table plus hand-written multi-cycle sequences.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_traffic_light_fsm;

    localparam logic [2:0] S_MG1  = 3'd0;
    localparam logic [2:0] S_MG2  = 3'd1;
    localparam logic [2:0] S_MY   = 3'd2;
    localparam logic [2:0] S_WALK = 3'd3;
    localparam logic [2:0] S_SG   = 3'd4;
    localparam logic [2:0] S_SGX  = 3'd5;
    localparam logic [2:0] S_SY   = 3'd6;

    logic       clk = 1'b0;
    logic       Reset = 1'b1;
    logic       Sensor_Sync = 1'b0;
    logic       WR_Sync = 1'b0;
    logic       Prog_Sync = 1'b0;
    logic       Tick = 1'b0;
    logic [2:0] LED_main;
    logic [2:0] LED_side;
    logic       Walk_Lamp;
    logic [2:0] State;

    int n_pass = 0;
    int n_total = 0;

    // Automatic Tick generation: one Tick every tp clocks
    bit auto_tick = 1'b0;
    int tp = 1;
    int ph = 0;

    // Vector: inputs {Tick,Sensor,WR,Prog} applied before an edge, state after it
    typedef struct {
        logic [3:0] in;
        logic [2:0] st;
    } vec_t;
    vec_t vecs[35];

    traffic_light_fsm dut (
        .clk         (clk),
        .Reset       (Reset),
        .Sensor_Sync (Sensor_Sync),
        .WR_Sync     (WR_Sync),
        .Prog_Sync   (Prog_Sync),
        .Tick        (Tick),
        .LED_main    (LED_main),
        .LED_side    (LED_side),
        .Walk_Lamp   (Walk_Lamp),
        .State       (State)
    );

    always #5 clk = ~clk;

    function automatic logic [2:0] f_main(logic [2:0] s);
        case (s)
            S_MG1, S_MG2: return 3'b001;
            S_MY:         return 3'b010;
            default:      return 3'b100;
        endcase
    endfunction

    function automatic logic [2:0] f_side(logic [2:0] s);
        case (s)
            S_SG, S_SGX: return 3'b001;
            S_SY:        return 3'b010;
            default:     return 3'b100;
        endcase
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic chk_all(string tag, logic [2:0] s);
        chk({tag, " State"},     {29'd0, State},     {29'd0, s});
        chk({tag, " LED_main"},  {29'd0, LED_main},  {29'd0, f_main(s)});
        chk({tag, " LED_side"},  {29'd0, LED_side},  {29'd0, f_side(s)});
        chk({tag, " Walk_Lamp"}, {31'd0, Walk_Lamp}, {31'd0, (s == S_WALK)});
    endtask

    task automatic step();
        if (auto_tick) Tick = (ph == tp - 1);
        @(posedge clk);
        #1;
        if (auto_tick) ph = (ph + 1) % tp;
    endtask

    // Check the expected state before each of n clocks, stepping after each
    task automatic hold(string tag, logic [2:0] s, int n);
        for (int i = 0; i < n; i++) begin
            chk_all($sformatf("%s[%0d]", tag, i), s);
            step();
        end
    endtask

    task automatic do_reset(string tag);
        @(negedge clk);
        Reset = 1'b1;
        Tick = 1'b0; Sensor_Sync = 1'b0; WR_Sync = 1'b0; Prog_Sync = 1'b0;
        #2;
        chk_all({tag, " reset"}, S_MG1);
        @(negedge clk);
        Reset = 1'b0;
        ph = 0;
    endtask

    initial begin
        // {Tick,Sensor,WR,Prog}, state after the edge
        vecs[0]  = '{4'b0000, S_MG1};   // no Tick: hold
        vecs[1]  = '{4'b1100, S_MG1};   // sensor mid-MG1 ignored, t=5
        vecs[2]  = '{4'b1000, S_MG1};   // t=4
        vecs[3]  = '{4'b1000, S_MG1};   // t=3
        vecs[4]  = '{4'b0100, S_MG1};   // no Tick
        vecs[5]  = '{4'b1000, S_MG1};   // t=2
        vecs[6]  = '{4'b1000, S_MG1};   // t=1
        vecs[7]  = '{4'b0000, S_MG1};   // counter at 1 but no Tick
        vecs[8]  = '{4'b1100, S_MG2};   // sensor on exit: MG2 = T_EXT
        vecs[9]  = '{4'b1000, S_MG2};
        vecs[10] = '{4'b1000, S_MG2};
        vecs[11] = '{4'b1000, S_MY};
        vecs[12] = '{4'b1010, S_MY};    // walk request during MY
        vecs[13] = '{4'b1000, S_WALK};  // served at this MY exit
        vecs[14] = '{4'b1010, S_WALK};  // request in WALK ignored
        vecs[15] = '{4'b1000, S_WALK};
        vecs[16] = '{4'b1000, S_SG};
        vecs[17] = '{4'b1000, S_SG};
        vecs[18] = '{4'b1000, S_SG};
        vecs[19] = '{4'b1000, S_SG};
        vecs[20] = '{4'b1000, S_SG};
        vecs[21] = '{4'b1000, S_SG};
        vecs[22] = '{4'b1100, S_SGX};   // sensor on SG exit
        vecs[23] = '{4'b1000, S_SGX};
        vecs[24] = '{4'b1000, S_SGX};
        vecs[25] = '{4'b1000, S_SY};
        vecs[26] = '{4'b1000, S_SY};
        vecs[27] = '{4'b1000, S_MG1};
        vecs[28] = '{4'b1011, S_MG1};   // Prog beats Tick and WR, timer back to 6
        vecs[29] = '{4'b1000, S_MG1};
        vecs[30] = '{4'b1000, S_MG1};
        vecs[31] = '{4'b1000, S_MG1};
        vecs[32] = '{4'b1000, S_MG1};
        vecs[33] = '{4'b1000, S_MG1};
        vecs[34] = '{4'b1000, S_MG2};   // six Ticks after the restart

        // Table-driven vectors
        do_reset("tbl");
        auto_tick = 1'b0;
        for (int i = 0; i < 35; i++) begin
            {Tick, Sensor_Sync, WR_Sync, Prog_Sync} = vecs[i].in;
            step();
            chk_all($sformatf("vec%0d", i), vecs[i].st);
        end

        // Tick tied high, no sensor, no walk: 22-clock period
        do_reset("base");
        auto_tick = 1'b1; tp = 1;
        hold("base MG1", S_MG1, 6);
        hold("base MG2", S_MG2, 6);
        hold("base MY",  S_MY,  2);
        hold("base SG",  S_SG,  6);
        hold("base SY",  S_SY,  2);
        hold("base MG1b", S_MG1, 6);
        chk_all("base MG2b", S_MG2);

        // Sensor held high: MG2 shortened, SGX inserted
        do_reset("sens");
        Sensor_Sync = 1'b1;
        hold("sens MG1", S_MG1, 6);
        hold("sens MG2", S_MG2, 3);
        hold("sens MY",  S_MY,  2);
        hold("sens SG",  S_SG,  6);
        hold("sens SGX", S_SGX, 3);
        hold("sens SY",  S_SY,  2);
        chk_all("sens MG1b", S_MG1);

        // One-clock walk pulse in MG1: single WALK phase, none next cycle
        do_reset("walk");
        WR_Sync = 1'b1;
        hold("walk MG1p", S_MG1, 1);
        WR_Sync = 1'b0;
        hold("walk MG1",  S_MG1, 5);
        hold("walk MG2",  S_MG2, 6);
        hold("walk MY",   S_MY,  2);
        hold("walk WALK", S_WALK, 3);
        hold("walk SG",   S_SG,  6);
        hold("walk SY",   S_SY,  2);
        hold("walk MG1b", S_MG1, 6);
        hold("walk MG2b", S_MG2, 6);
        hold("walk MYb",  S_MY,  2);
        chk_all("walk SGb", S_SG);

        // Prog with Tick during SG discards a pending walk request
        do_reset("prog");
        hold("prog MG1", S_MG1, 6);
        hold("prog MG2", S_MG2, 6);
        hold("prog MY",  S_MY,  2);
        WR_Sync = 1'b1;
        hold("prog SGw", S_SG, 1);
        WR_Sync = 1'b0;
        hold("prog SG",  S_SG, 1);
        Prog_Sync = 1'b1;
        step();
        chk_all("prog entry", S_MG1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk_all($sformatf("prog held%0d", i), S_MG1);
        end
        Prog_Sync = 1'b0;
        hold("prog MG1r", S_MG1, 6);
        hold("prog MG2r", S_MG2, 6);
        hold("prog MYr",  S_MY,  2);
        chk_all("prog SGr", S_SG);

        // Asynchronous reset between edges in SY
        do_reset("arst");
        hold("arst MG1", S_MG1, 6);
        hold("arst MG2", S_MG2, 6);
        hold("arst MY",  S_MY,  2);
        hold("arst SG",  S_SG,  6);
        chk_all("arst SY", S_SY);
        step();
        chk_all("arst SY2", S_SY);
        #3;
        Reset = 1'b1;
        #1;
        chk_all("arst async", S_MG1);
        #2;
        Reset = 1'b0;
        ph = 0;
        hold("arst MG1r", S_MG1, 6);
        chk_all("arst MG2r", S_MG2);

        // Tick every 4th clock: every duration scales by 4, no change between Ticks
        do_reset("slow");
        tp = 4;
        hold("slow MG1", S_MG1, 24);
        hold("slow MG2", S_MG2, 24);
        hold("slow MY",  S_MY,  8);
        hold("slow SG",  S_SG,  24);
        hold("slow SY",  S_SY,  8);
        chk_all("slow MG1b", S_MG1);

        auto_tick = 1'b0;
        Tick = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
